// File: rtl/sram_burst_ctrl.sv
// Burst controller for an 8-bit single-port SRAM: sequences one access per cycle,
// owns the tri-state data bus and returns read beats as an unthrottled stream.
module sram_burst_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_TURN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_nxt;
  logic                  cs_nxt, we_nxt, oe_nxt;
  logic [ADDR_WIDTH-1:0] maddr_nxt;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic [READ_LAT-1:0]   vld_pipe;

  assign req_ready = (state == S_IDLE);
  assign wr_ready  = (state == S_WR);
  assign busy      = (state != S_IDLE);
  assign mem_data  = mem_oe ? {DATA_WIDTH{1'bz}} : wdata_q;

  // addr_q/cnt_q describe the next beat to issue; pins are the registered copy.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    cnt_nxt   = cnt_q;
    cs_nxt    = 1'b0;
    we_nxt    = 1'b0;
    oe_nxt    = 1'b1;
    maddr_nxt = mem_addr;
    wdata_nxt = wdata_q;
    case (state)
      S_IDLE: if (req_valid) begin
        cnt_nxt = req_len;
        if (req_we) begin
          state_nxt = S_WR;
          addr_nxt  = req_addr;
        end else begin
          // Beat 0 of a read goes out on the pins right after acceptance.
          state_nxt = S_RD;
          cs_nxt    = 1'b1;
          maddr_nxt = req_addr;
          addr_nxt  = req_addr + ADDR_WIDTH'(1);
        end
      end
      S_WR: if (wr_valid) begin
        cs_nxt    = 1'b1;
        we_nxt    = 1'b1;
        oe_nxt    = 1'b0;
        maddr_nxt = addr_q;
        wdata_nxt = wr_data;
        addr_nxt  = addr_q + ADDR_WIDTH'(1);
        if (cnt_q == '0) state_nxt = S_IDLE;
        else             cnt_nxt   = cnt_q - LEN_WIDTH'(1);
      end
      S_RD: begin
        if (cnt_q == '0) begin
          state_nxt = S_DRAIN;
        end else begin
          cs_nxt    = 1'b1;
          maddr_nxt = addr_q;
          addr_nxt  = addr_q + ADDR_WIDTH'(1);
          cnt_nxt   = cnt_q - LEN_WIDTH'(1);
        end
      end
      S_DRAIN: if (vld_pipe == '0) state_nxt = S_TURN;
      S_TURN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_oe   <= 1'b1;
      mem_addr <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_nxt;
      cnt_q    <= cnt_nxt;
      mem_cs   <= cs_nxt;
      mem_we   <= we_nxt;
      mem_oe   <= oe_nxt;
      mem_addr <= maddr_nxt;
      wdata_q  <= wdata_nxt;
    end
  end

  // A read is sampled by the SRAM at the edge where the pins show it; its data
  // is on the bus READ_LAT edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      vld_pipe[0] <= mem_cs & ~mem_we;
      for (int i = 1; i < READ_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      rsp_valid <= vld_pipe[READ_LAT-1];
      if (vld_pipe[READ_LAT-1]) rsp_data <= mem_data;
    end
  end

endmodule
